// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - sequential 1-bit-per-cycle shifter (SLL, optional SRA via SHIFT_SEQ_SRA_EN)
module shift_seq_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] acc;
    logic [4:0]  cnt;

`ifdef SHIFT_SEQ_SRA_EN
    logic        op_q;
`else
    // op has no function in a left-shift-only build
    logic        unused_op;
    assign unused_op = op;
`endif

    // the accumulator is the result; intermediate stages are visible while shifting
    assign result = acc;

    // control FSM: state, accumulator, remaining count and one-hot status flags
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            acc   <= 32'd0;
            cnt   <= 5'd0;
`ifdef SHIFT_SEQ_SRA_EN
            op_q  <= 1'b0;
`endif
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= data_in;
                        cnt  <= shamt;
`ifdef SHIFT_SEQ_SRA_EN
                        op_q <= op;
`endif
                        ready <= 1'b0;
                        if (shamt != 5'd0) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
`ifdef SHIFT_SEQ_SRA_EN
                    if (op_q) begin
                        acc <= {acc[31], acc[31:1]};
                    end else begin
                        acc <= {acc[30:0], 1'b0};
                    end
`else
                    acc <= {acc[30:0], 1'b0};
`endif
                    cnt <= cnt - 5'd1;
                    // leaving at cnt==1 means cnt never decrements past zero
                    if (cnt == 5'd1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        ready;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    shift_seq_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .result  (result),
        .ready   (ready),
        .busy    (busy),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // launch one operation and follow it to its done pulse (bounded)
    task automatic run_op(input logic o, input logic [31:0] d, input logic [4:0] s,
                          output int lat, output int busy_n, output int oh_err,
                          output logic [31:0] res);
        lat = 0; busy_n = 0; oh_err = 0;
        op = o; data_in = d; shamt = s; start = 1'b1;
        tick;
        start = 1'b0;
        lat = 1;
        if ($countones({ready, busy, done}) != 1) oh_err++;
        while (!done && lat < 64) begin
            if (busy) busy_n++;
            tick;
            lat++;
            if ($countones({ready, busy, done}) != 1) oh_err++;
        end
        res = result;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b1; op = 1'b1; data_in = 32'hFFFF_FFFF; shamt = 5'd7;
        tick; tick;
        n_cmp++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h want=%h", result, 32'd0); end
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        start = 1'b0; reset = 1'b1;
        tick;
        n_cmp++; if (ready !== 1'b1 || result !== 32'd0) begin n_fail++; $display("FAIL idle_hold got ready=%b result=%h want ready=1 result=0", ready, result); end
    endtask

    task automatic test_sll_basic;
        int lat, bn, oh; logic [31:0] r;
        run_op(1'b0, 32'h0000_0001, 5'd4, lat, bn, oh, r);
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL sll4_latency got=%0d want=5", lat); end
        n_cmp++; if (bn !== 4) begin n_fail++; $display("FAIL sll4_busy_cycles got=%0d want=4", bn); end
        n_cmp++; if (r !== 32'h0000_0010) begin n_fail++; $display("FAIL sll4_result got=%h want=00000010", r); end
        n_cmp++; if (oh !== 0) begin n_fail++; $display("FAIL sll4_onehot got=%0d want=0", oh); end
        tick;
        n_cmp++; if (done !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL sll4_done_pulse got done=%b ready=%b want done=0 ready=1", done, ready); end
        tick; tick;
        n_cmp++; if (result !== 32'h0000_0010) begin n_fail++; $display("FAIL sll4_hold got=%h want=00000010", result); end
    endtask

    task automatic test_sra_max;
        int lat, bn, oh; logic [31:0] r; logic [31:0] exp_r;
`ifdef SHIFT_SEQ_SRA_EN
        exp_r = 32'hFFFF_FFFF;
`else
        exp_r = 32'h0000_0000;
`endif
        run_op(1'b1, 32'h8000_0000, 5'd31, lat, bn, oh, r);
        n_cmp++; if (lat !== 32) begin n_fail++; $display("FAIL sh31_latency got=%0d want=32", lat); end
        n_cmp++; if (bn !== 31) begin n_fail++; $display("FAIL sh31_busy_cycles got=%0d want=31", bn); end
        n_cmp++; if (r !== exp_r) begin n_fail++; $display("FAIL sh31_result got=%h want=%h", r, exp_r); end
        n_cmp++; if (oh !== 0) begin n_fail++; $display("FAIL sh31_onehot got=%0d want=0", oh); end
        tick;
    endtask

    task automatic test_shamt_zero;
        int lat, bn, oh; logic [31:0] r;
        run_op(1'b0, 32'hDEAD_BEEF, 5'd0, lat, bn, oh, r);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL sh0_latency got=%0d want=1", lat); end
        n_cmp++; if (bn !== 0) begin n_fail++; $display("FAIL sh0_busy_cycles got=%0d want=0", bn); end
        n_cmp++; if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sh0_result got=%h want=deadbeef", r); end
        tick;
    endtask

    task automatic test_start_ignored;
        int lat;
        op = 1'b0; data_in = 32'h0000_00FF; shamt = 5'd8; start = 1'b1;
        tick;
        start = 1'b0; lat = 1;
        n_cmp++; if (result !== 32'h0000_00FF) begin n_fail++; $display("FAIL ign_load got=%h want=000000ff", result); end
        tick; lat++;
        n_cmp++; if (result !== 32'h0000_01FE) begin n_fail++; $display("FAIL ign_stage1 got=%h want=000001fe", result); end
        op = 1'b1; data_in = 32'h1234_5678; shamt = 5'd3; start = 1'b1;
        tick; lat++;
        start = 1'b0;
        while (!done && lat < 64) begin
            tick; lat++;
        end
        n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL ign_latency got=%0d want=9", lat); end
        n_cmp++; if (result !== 32'h0000_FF00) begin n_fail++; $display("FAIL ign_result got=%h want=0000ff00", result); end
        tick;
    endtask

    task automatic test_reset_abort;
        int done_n; int lat, bn, oh; logic [31:0] r;
        op = 1'b0; data_in = 32'h0000_0001; shamt = 5'd10; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_in_shift got busy=%b want=1", busy); end
        reset = 1'b0;
        tick;
        reset = 1'b1;
        n_cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_state got ready=%b busy=%b want ready=1 busy=0", ready, busy); end
        n_cmp++; if (result !== 32'd0) begin n_fail++; $display("FAIL abort_result got=%h want=0", result); end
        done_n = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (done) done_n++;
        end
        n_cmp++; if (done_n !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d want=0", done_n); end
        run_op(1'b0, 32'h0000_0005, 5'd3, lat, bn, oh, r);
        n_cmp++; if (lat !== 4 || r !== 32'h0000_0028) begin n_fail++; $display("FAIL post_reset_op got lat=%0d result=%h want lat=4 result=00000028", lat, r); end
        tick;
    endtask

    task automatic test_op_one;
        int lat, bn, oh; logic [31:0] r; logic [31:0] exp_r;
`ifdef SHIFT_SEQ_SRA_EN
        exp_r = 32'hC000_0000;
`else
        exp_r = 32'h0000_0002;
`endif
        run_op(1'b1, 32'h8000_0001, 5'd1, lat, bn, oh, r);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL op1_latency got=%0d want=2", lat); end
        n_cmp++; if (r !== exp_r) begin n_fail++; $display("FAIL op1_result got=%h want=%h", r, exp_r); end
        tick;
    endtask

    task automatic test_back_to_back;
        int lat, bn, oh; logic [31:0] r;
        run_op(1'b0, 32'h0000_0003, 5'd2, lat, bn, oh, r);
        n_cmp++; if (r !== 32'h0000_000C) begin n_fail++; $display("FAIL b2b_first got=%h want=0000000c", r); end
        tick;
        run_op(1'b0, 32'h0000_0101, 5'd4, lat, bn, oh, r);
        n_cmp++; if (lat !== 5 || r !== 32'h0000_1010) begin n_fail++; $display("FAIL b2b_second got lat=%0d result=%h want lat=5 result=00001010", lat, r); end
        tick;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 1'b0; data_in = 32'd0; shamt = 5'd0;
        test_reset;
        test_sll_basic;
        test_sra_max;
        test_shamt_zero;
        test_start_ignored;
        test_reset_abort;
        test_op_one;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit, synchronous active-low reset sampled on the rising clock edge.
REQ-003 The block SHALL have the port start, input, 1 bit, request to begin a shift; accepted only when ready=1.
REQ-004 The block SHALL have the port op, input, 1 bit, operation select: 0 = logical left shift (SLL), 1 = arithmetic right shift (SRA); sampled with start.
REQ-005 The block SHALL have the port data_in, input, 32 bits, operand; sampled with start.
REQ-006 The block SHALL have the port shamt, input, 5 bits, shift amount 0..31; sampled with start.
REQ-007 The block SHALL have the port result, output, 32 bits, shift accumulator contents.
REQ-008 The block SHALL have the port ready, output, 1 bit, high in IDLE only.
REQ-009 The block SHALL have the port busy, output, 1 bit, high in SHIFT only.
REQ-010 The block SHALL have the port done, output, 1 bit, single-cycle pulse high in DONE only.

Function
REQ-011 The block SHALL implement states IDLE, SHIFT, DONE, with exactly one of ready/busy/done high in every cycle.
REQ-012 In IDLE with start=1, the next edge SHALL load acc<=data_in, cnt<=shamt, latch op, and enter SHIFT if shamt!=0, else DONE.
REQ-013 In IDLE with start=0, the state, acc, cnt and op SHALL hold.
REQ-014 Each SHIFT edge SHALL apply exactly one 1-bit shift stage to acc and decrement cnt by 1.
REQ-015 The SLL stage SHALL set acc[0]<=0 and acc[i]<=acc[i-1] for i=1..31.
REQ-016 The SRA stage SHALL set acc[31]<=acc[31] and acc[i]<=acc[i+1] for i=0..30.
REQ-017 A SHIFT edge with cnt==1 SHALL enter DONE; any other SHIFT edge SHALL remain in SHIFT.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 The done pulse SHALL begin shamt+1 cycles after the edge at which start was accepted; shamt=0 gives 1 cycle.
REQ-020 In DONE, result SHALL equal data_in shifted by shamt per op.
REQ-021 result SHALL hold that value through IDLE until the next accepted start.
REQ-022 result SHALL equal acc at all times, including intermediate values during SHIFT.
REQ-023 start SHALL be ignored in SHIFT and DONE; data_in, shamt and op changes there SHALL have no effect.
REQ-024 cnt SHALL be 5 bits wide; shamt=31 SHALL take 31 SHIFT cycles, and cnt SHALL never wrap below 0.

Reset
REQ-025 reset=0 at an edge SHALL force IDLE, acc=0, cnt=0 and latched op=0, giving result=0, ready=1, busy=0, done=0.
REQ-026 Reset SHALL take priority over start and over any in-progress SHIFT or DONE, aborting the operation with no done pulse.
REQ-027 The first start after reset is released SHALL be accepted normally.

Configuration
REQ-028 Macro SHIFT_SEQ_SRA_EN SHALL control SRA support.
REQ-029 With SHIFT_SEQ_SRA_EN defined, op SHALL select SLL or SRA as specified above.
REQ-030 Without SHIFT_SEQ_SRA_EN, op SHALL be ignored, every operation SHALL be SLL, and no right-shift logic SHALL be present.
REQ-031 Timing and handshake SHALL be identical in both configurations.

Verification
REQ-032 The bench SHALL cover: start, op=0, data_in=0x0000_0001, shamt=4 -> busy for 4 cycles, done 5 cycles after accept, result=0x0000_0010.
REQ-033 The bench SHALL cover: start, op=1 (SRA_EN defined), data_in=0x8000_0000, shamt=31 -> done 32 cycles after accept, result=0xFFFF_FFFF.
REQ-034 The bench SHALL cover: start, shamt=0, data_in=0xDEAD_BEEF -> no busy cycle, done the next cycle, result=0xDEAD_BEEF.
REQ-035 The bench SHALL cover: start pulsed with data_in=0x1234_5678 during SHIFT of a shamt=8 SLL on 0x0000_00FF -> ignored, result=0x0000_FF00.
REQ-036 The bench SHALL cover: reset=0 on the 3rd SHIFT cycle of shamt=10 -> next cycle ready=1, result=0, and no done pulse follows.
REQ-037 The bench SHALL cover: build without SHIFT_SEQ_SRA_EN, op=1, data_in=0x8000_0001, shamt=1 -> result=0x0000_0002.
